// File: rtl/pwm_pkg.sv
// pwm_pkg: register-select encodings and ctrl bit positions shared by the PWM bank.
package pwm_pkg;
  typedef enum logic [1:0] {
    REG_PERIOD = 2'd0,
    REG_DUTY   = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;
  localparam int CTRL_EN  = 0;
  localparam int CTRL_POL = 1;
endpackage

// File: rtl/pwm_bank_if.sv
// pwm_bank_if: host register-write bus into the PWM bank.
interface pwm_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  logic          wr_en;
  logic [CW-1:0] wr_ch;
  logic [1:0]    wr_reg;
  logic [WIDTH-1:0] wr_data;
  modport master (output wr_en, wr_ch, wr_reg, wr_data);
  modport slave  (input  wr_en, wr_ch, wr_reg, wr_data);
endinterface

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM counter with shadowed period/duty and a registered output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             wr_period,
  input  logic             wr_duty,
  input  logic             wr_ctrl,
  input  logic [WIDTH-1:0] wr_data,
  output logic             pwm_out,
  output logic             cycle_start
);
  logic [WIDTH-1:0] cnt, per_p, duty_p, per_a, duty_a;
  logic en, pol, en_n, start, wrap, load;
  always_comb begin
    en_n  = wr_ctrl ? wr_data[CTRL_EN] : en;
    start = en_n & ~en;
    wrap  = en & en_n & tick & (cnt == per_a);
    load  = ~en_n | start | wrap;
  end
  // Pending values are sampled before this cycle's write lands, so a write coincident with a wrap waits one more cycle.
  always_ff @(posedge clk)
    if (reset) begin
      cnt         <= '0;
      per_p       <= '0;
      duty_p      <= '0;
      per_a       <= '0;
      duty_a      <= '0;
      en          <= 1'b0;
      pol         <= 1'b0;
      pwm_out     <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      if (wr_period) per_p <= wr_data;
      if (wr_duty) duty_p <= wr_data;
      if (wr_ctrl) begin
        en  <= wr_data[CTRL_EN];
        pol <= wr_data[CTRL_POL];
      end
      cnt <= load ? '0 : tick ? cnt + WIDTH'(1) : cnt;
      if (load) begin
        per_a  <= per_p;
        duty_a <= duty_p;
      end
      cycle_start <= start | wrap;
      pwm_out     <= (en & (cnt < duty_a)) ^ pol;
    end
endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: shared prescaler and write decode driving CHANNELS pwm_channel instances.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESC_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PRESC_W-1:0]  prescale,
  pwm_bank_if.slave           bus,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] cycle_start
);
  logic [PRESC_W-1:0] pcnt;
  logic tick;
  // >= rather than == so lowering prescale below the running count ticks at once.
  assign tick = pcnt >= prescale;
  always_ff @(posedge clk)
    if (reset) pcnt <= '0;
    else pcnt <= tick ? '0 : pcnt + PRESC_W'(1);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic sel;
    assign sel = bus.wr_en && (int'(bus.wr_ch) == c);
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .wr_period   (sel && bus.wr_reg == REG_PERIOD),
      .wr_duty     (sel && bus.wr_reg == REG_DUTY),
      .wr_ctrl     (sel && bus.wr_reg == REG_CTRL),
      .wr_data     (bus.wr_data),
      .pwm_out     (pwm_out[c]),
      .cycle_start (cycle_start[c])
    );
  end
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: table, directed and random checks of pwm_bank against a cycle-level reference model.
module tb_pwm_bank;
  import pwm_pkg::*;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] prescale = '0;
  logic [N-1:0] pwm_out, cycle_start;
  pwm_bank_if #(.CHANNELS(N), .WIDTH(W)) bus ();
  pwm_bank #(.CHANNELS(N), .WIDTH(W), .PRESC_W(16)) dut (
    .clk(clk), .reset(reset), .prescale(prescale), .bus(bus),
    .pwm_out(pwm_out), .cycle_start(cycle_start)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int m_pc;
  int m_en[N], m_pol[N], m_pp[N], m_pd[N], m_ap[N], m_ad[N], m_cnt[N];
  logic [N-1:0] m_out, m_cs;
  typedef struct {int per; int duty; int ctrl; int exp;} vec_t;
  vec_t tbl[8];
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: prescaler ticks when its count reaches prescale; each enabled channel steps per tick through period+1 counts.
  function automatic void model_step();
    bit tick;
    int hit, en_n, pol_n, start, wrap;
    if (reset) begin
      m_pc = 0;
      for (int i = 0; i < N; i++) begin
        m_en[i] = 0; m_pol[i] = 0; m_pp[i] = 0; m_pd[i] = 0;
        m_ap[i] = 0; m_ad[i] = 0; m_cnt[i] = 0;
      end
      m_out = '0;
      m_cs = '0;
      return;
    end
    tick = m_pc >= int'(prescale);
    m_pc = tick ? 0 : m_pc + 1;
    for (int i = 0; i < N; i++) begin
      hit = (bus.wr_en && int'(bus.wr_ch) == i) ? 1 : 0;
      m_out[i] = ((m_en[i] != 0 && m_cnt[i] < m_ad[i]) != (m_pol[i] != 0));
      en_n  = (hit != 0 && bus.wr_reg == 2'd2) ? int'(bus.wr_data[0]) : m_en[i];
      pol_n = (hit != 0 && bus.wr_reg == 2'd2) ? int'(bus.wr_data[1]) : m_pol[i];
      start = (en_n != 0 && m_en[i] == 0) ? 1 : 0;
      wrap  = (m_en[i] != 0 && en_n != 0 && tick && m_cnt[i] == m_ap[i]) ? 1 : 0;
      m_cs[i] = (start != 0 || wrap != 0);
      if (en_n == 0 || start != 0 || wrap != 0) begin
        m_cnt[i] = 0;
        m_ap[i] = m_pp[i];
        m_ad[i] = m_pd[i];
      end else if (tick) m_cnt[i] = m_cnt[i] + 1;
      if (hit != 0 && bus.wr_reg == 2'd0) m_pp[i] = int'(bus.wr_data);
      if (hit != 0 && bus.wr_reg == 2'd1) m_pd[i] = int'(bus.wr_data);
      m_en[i] = en_n;
      m_pol[i] = pol_n;
    end
  endfunction
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("pwm_out", int'(pwm_out), int'(m_out));
    check("cycle_start", int'(cycle_start), int'(m_cs));
  endtask
  task automatic wr(int ch, int r, int d);
    bus.wr_en = 1'b1;
    bus.wr_ch = 2'(ch);
    bus.wr_reg = 2'(r);
    bus.wr_data = 8'(d);
    cyc();
    bus.wr_en = 1'b0;
  endtask
  task automatic wait_cs(int ch);
    int b = 0;
    while (!cycle_start[ch] && b < 300) begin
      cyc();
      b++;
    end
    check("cs_timeout", int'(cycle_start[ch]), 1);
  endtask
  task automatic run_cycle(int ch, int nclk, int wr_at, int wr_val, output int n, output int ncs);
    wait_cs(ch);
    n = 0;
    ncs = 0;
    for (int k = 0; k < nclk; k++) begin
      if (k == wr_at) begin
        bus.wr_en = 1'b1;
        bus.wr_ch = 2'(ch);
        bus.wr_reg = 2'd1;
        bus.wr_data = 8'(wr_val);
      end
      cyc();
      bus.wr_en = 1'b0;
      n += int'(pwm_out[ch]);
      ncs += int'(cycle_start[ch]);
    end
  endtask
  initial begin
    int n, ncs, p2, b;
    bus.wr_en = 1'b0;
    bus.wr_ch = '0;
    bus.wr_reg = '0;
    bus.wr_data = '0;
    tbl[0] = '{9, 0, 1, 0};
    tbl[1] = '{99, 200, 1, 1};
    tbl[2] = '{9, 0, 3, 1};
    tbl[3] = '{99, 200, 3, 0};
    tbl[4] = '{9, 3, 2, 1};
    tbl[5] = '{9, 3, 0, 0};
    tbl[6] = '{0, 5, 1, 1};
    tbl[7] = '{0, 0, 1, 0};
    repeat (3) cyc();
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_cs", int'(cycle_start), 0);
    reset = 1'b0;
    repeat (3) cyc();
    check("idle_pwm", int'(pwm_out), 0);
    for (int t = 0; t < 8; t++) begin
      wr(0, 2, 0);
      wr(0, 0, tbl[t].per);
      wr(0, 1, tbl[t].duty);
      wr(0, 2, tbl[t].ctrl);
      repeat (2) cyc();
      for (int k = 0; k < 12; k++) begin
        cyc();
        check($sformatf("tbl%0d_level", t), int'(pwm_out[0]), tbl[t].exp);
      end
    end
    wr(0, 2, 0);
    wr(0, 0, 9);
    wr(0, 1, 3);
    wr(0, 2, 1);
    run_cycle(0, 10, -1, 0, n, ncs);
    check("p0_high", n, 3);
    check("p0_cs_count", ncs, 1);
    run_cycle(0, 10, -1, 0, n, ncs);
    check("p0_high_2", n, 3);
    check("p0_cs_last", int'(cycle_start[0]), 1);
    prescale = 16'd4;
    run_cycle(0, 50, -1, 0, n, ncs);
    run_cycle(0, 50, -1, 0, n, ncs);
    check("p4_high", n, 15);
    check("p4_cs_count", ncs, 1);
    prescale = 16'd0;
    wr(1, 0, 7);
    wr(1, 1, 2);
    wr(1, 2, 1);
    run_cycle(1, 8, -1, 0, n, ncs);
    check("ch1_base", n, 2);
    run_cycle(1, 8, 1, 6, n, ncs);
    check("ch1_midwrite_cur", n, 2);
    run_cycle(1, 8, -1, 0, n, ncs);
    check("ch1_midwrite_next", n, 6);
    run_cycle(1, 8, 7, 1, n, ncs);
    check("ch1_coinc_cur", n, 6);
    run_cycle(1, 8, -1, 0, n, ncs);
    check("ch1_coinc_next", n, 6);
    run_cycle(1, 8, -1, 0, n, ncs);
    check("ch1_coinc_applied", n, 1);
    prescale = 16'd1;
    p2 = 0;
    for (int c = 0; c < N; c++) begin
      int per, pol;
      per = int'($urandom_range(3, 20));
      pol = int'($urandom_range(0, 1));
      if (c == 2) p2 = pol;
      wr(c, 0, per);
      wr(c, 1, int'($urandom_range(0, per + 2)));
      wr(c, 2, 1 | (pol << 1));
    end
    repeat (60) cyc();
    wr(2, 2, p2 << 1);
    cyc();
    check("ch2_idle", int'(pwm_out[2]), p2);
    repeat (40) cyc();
    check("ch2_still_idle", int'(pwm_out[2]), p2);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.wr_en = 1'b1;
        bus.wr_ch = 2'($urandom_range(0, N - 1));
        bus.wr_reg = 2'($urandom_range(0, 3));
        bus.wr_data = 8'($urandom_range(0, 40));
      end
      if ($urandom_range(0, 49) == 0) prescale = 16'($urandom_range(0, 3));
      cyc();
      bus.wr_en = 1'b0;
    end
    reset = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_ch = 2'd0;
    bus.wr_reg = 2'd2;
    bus.wr_data = 8'd3;
    cyc();
    bus.wr_en = 1'b0;
    check("rst_mid_pwm", int'(pwm_out), 0);
    check("rst_mid_cs", int'(cycle_start), 0);
    reset = 1'b0;
    prescale = 16'd0;
    repeat (5) cyc();
    check("post_rst_pwm", int'(pwm_out), 0);
    check("post_rst_cs", int'(cycle_start), 0);
    wr(0, 2, 1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("cleared_per_cs", int'(cycle_start[0]), 1);
      check("cleared_duty_pwm", int'(pwm_out[0]), 0);
    end
    prescale = 16'd100;
    b = 0;
    while (m_pc != 50 && b < 300) begin
      cyc();
      b++;
    end
    check("presc_reach50", m_pc, 50);
    prescale = 16'd2;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check($sformatf("presc_cs_%0d", k), int'(cycle_start[0]), (k % 3 == 1) ? 1 : 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent PWM channels (1..16).
REQ-002 Parameter WIDTH, default 8, bit width of period, duty and channel counters.
REQ-003 Parameter PRESC_W, default 16, bit width of the shared prescaler.
REQ-004 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port prescale  input  PRESC_W  tick divisor; one tick every prescale+1 clk cycles.
REQ-007 Port wr_en  input  1  register write strobe, single-cycle.
REQ-008 Port wr_ch  input  $clog2(CHANNELS) (min 1)  target channel index.
REQ-009 Port wr_reg  input  2  target register: 0=period, 1=duty, 2=ctrl, 3=reserved.
REQ-010 Port wr_data  input  WIDTH  write data; for ctrl: bit0=enable, bit1=polarity.
REQ-011 Port pwm_out  output  CHANNELS  registered PWM outputs.
REQ-012 Port cycle_start  output  CHANNELS  one-clk pulse per channel when its counter wraps to 0.

Function
REQ-013 The prescaler SHALL count 0..prescale and assert an internal tick in the cycle where count >= prescale, then return to 0; prescale=0 SHALL tick every clk.
REQ-014 A prescale reduction below the current count SHALL produce a tick on the next clk (>= compare), no wrap through 2^PRESC_W.
REQ-015 Each channel SHALL hold pending period/duty (written by host) and active period/duty (used by counter).
REQ-016 Writes to period/duty SHALL update only pending registers; wr_ch >= CHANNELS or wr_reg=3 SHALL be ignored.
REQ-017 Active registers SHALL load from pending at wrap only: on a tick where cnt == active_period, cnt becomes 0 and active loads.
REQ-018 A write landing in the same clk as a wrap SHALL NOT be used at that wrap; it applies at the following wrap.
REQ-019 Ctrl writes SHALL take effect immediately (not shadowed).
REQ-020 Enabled channel: on each tick cnt increments by 1, wrapping after active_period (cycle length active_period+1 ticks).
REQ-021 Raw level = (cnt < active_duty); duty=0 -> constant low; duty > active_period -> constant high.
REQ-022 pwm_out[i] SHALL equal raw level XOR polarity, registered, updating one clk after the cnt change.
REQ-023 Disabled channel: cnt held 0, active registers continuously track pending, pwm_out = polarity (idle level), cycle_start low.
REQ-024 Enable 0->1: cnt starts at 0 with active = pending; cycle_start pulses in that clk's following cycle; first high phase begins immediately.
REQ-025 Disable mid-cycle: output goes to idle level the next clk; no completion of the current period.
REQ-026 cycle_start[i] SHALL pulse for exactly one clk after each wrap and after each enable rising edge.
REQ-027 period=0 SHALL wrap on every tick; output constant (high iff duty>0, before polarity).
REQ-028 All arithmetic is unsigned WIDTH-bit; no counter may exceed active_period.

Reset
REQ-029 Reset SHALL clear prescaler count, all cnt, pending and active period/duty, enable and polarity to 0.
REQ-030 During and after reset pwm_out = 0 and cycle_start = 0 until a channel is enabled.
REQ-031 Reset asserted mid-period SHALL override any concurrent write or tick in the same clk.

Structure
REQ-032 Register-select encodings (PERIOD, DUTY, CTRL) and ctrl bit positions SHALL live in shared package pwm_pkg.
REQ-033 One sub-module pwm_channel (counter, shadow/active registers, output register) SHALL be instantiated CHANNELS times; prescaler and write decode stay in pwm_bank.

Verification
REQ-034 prescale=0, ch0 period=9, duty=3, enable -> pwm_out[0] high 3 clk, low 7 clk, period 10 clk; cycle_start every 10 clk.
REQ-035 prescale=4, same ch0 -> high 15 clk, low 35 clk; ticks every 5 clk.
REQ-036 ch1 running duty=2 period=7; write duty=6 mid-cycle -> current cycle still 2 high; next cycle 6 high; write coincident with wrap -> applies one cycle later.
REQ-037 duty=0 -> constant low; duty=200 with period=99 -> constant high; polarity=1 inverts both; disabled with polarity=1 -> output 1.
REQ-038 All 4 channels different settings, disable ch2 mid-cycle -> ch2 idle next clk, others undisturbed; reset mid-run -> all outputs 0, registers cleared.
REQ-039 prescale changed 100->2 while count=50 -> tick next clk, then every 3 clk.
